// File: rtl/ram_sp_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_sp_req_ctrl
// Description : Request-side controller for a single-port write-first block
//               RAM. It accepts valid/ready read/write requests and drives the
//               RAM port in the same cycle. It tracks the fixed RAM read latency
//               with a tag pipeline and returns read data in request order
//               through a credit-protected first-word-fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sp_req_ctrl #(
  parameter int WORD_BIT_WIDTH = 32,
  parameter int DEPTH          = 8,
  parameter int READ_LATENCY   = 1,
  localparam int AW            = $clog2(DEPTH),
  localparam int BE_W          = WORD_BIT_WIDTH / 8
) (
  input  logic                      i_clk,
  input  logic                      i_sync_rst,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_we,
  input  logic [AW-1:0]             i_req_addr,
  input  logic [WORD_BIT_WIDTH-1:0] i_req_data,
  input  logic [BE_W-1:0]           i_req_byte_en,
  output logic                      o_ram_we,
  output logic [AW-1:0]             o_ram_word_addr,
  output logic [WORD_BIT_WIDTH-1:0] o_ram_data,
  output logic [BE_W-1:0]           o_ram_wr_byte_en,
  input  logic [WORD_BIT_WIDTH-1:0] i_ram_data,
  output logic                      o_rsp_valid,
  input  logic                      i_rsp_ready,
  output logic [WORD_BIT_WIDTH-1:0] o_rsp_data
);

  // The FIFO must hold every read in flight: latency stages, capture, and one
  // cycle for the response fire to return its credit.
  localparam int RSP_DEPTH = READ_LATENCY + 2;
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W     = $clog2(RSP_DEPTH);

  localparam logic [CNT_W-1:0] C_RSP_DEPTH = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_LAST  = PTR_W'(RSP_DEPTH - 1);

  generate
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("ram_sp_req_ctrl: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  logic                      w_req_fire;
  logic                      w_rd_fire;
  logic                      w_rsp_fire;
  logic                      w_push;
  logic [CNT_W-1:0]          r_outstanding;
  logic [READ_LATENCY-1:0]   r_tag;
  logic [WORD_BIT_WIDTH-1:0] r_fifo [RSP_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [CNT_W-1:0]          r_count;

  // Pointer advance with explicit wrap, since the depth need not be a power of 2.
  function automatic logic [PTR_W-1:0] f_ptr_next(input logic [PTR_W-1:0] p);
    return (p == C_PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshakes, credit check and RAM port pass-through.
  always_comb begin
    o_req_ready      = !i_sync_rst && (i_req_we || (r_outstanding < C_RSP_DEPTH));
    w_req_fire       = i_req_valid && o_req_ready;
    w_rd_fire        = w_req_fire && !i_req_we;
    o_ram_we         = w_req_fire && i_req_we;
    o_ram_word_addr  = i_req_addr;
    o_ram_data       = i_req_data;
    o_ram_wr_byte_en = o_ram_we ? i_req_byte_en : '0;
    o_rsp_valid      = (r_count != '0);
    o_rsp_data       = r_fifo[r_rd_ptr];
    w_rsp_fire       = o_rsp_valid && i_rsp_ready;
    w_push           = r_tag[READ_LATENCY-1];
  end

  // Reads accepted but not yet returned; no same-cycle credit return.
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      r_outstanding <= '0;
    end else begin
      case ({w_rd_fire, w_rsp_fire})
        2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Tag pipeline marks which RAM output cycles carry requested read data.
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= w_rd_fire;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  // Response FIFO storage; contents need no reset since the count gates them.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= i_ram_data;
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_sync_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= f_ptr_next(r_wr_ptr);
      end
      if (w_rsp_fire) begin
        r_rd_ptr <= f_ptr_next(r_rd_ptr);
      end
      case ({w_push, w_rsp_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The credit scheme guarantees a push never lands on a full FIFO.
  always_ff @(posedge i_clk) begin
    if (!i_sync_rst && w_push && !w_rsp_fire) begin
      a_no_overflow: assert (r_count < C_RSP_DEPTH);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_sp_req_ctrl
// Description : Directed and random bench for ram_sp_req_ctrl. Two instances
//               (read latency 1 and 2) share the request stimulus; each has its
//               own behavioral write-first RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_sp_req_ctrl;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [2:0]        req_addr = '0;
  logic [31:0]       req_data = '0;
  logic [3:0]        req_be = '0;
  logic              rsp_ready = 1'b0;

  logic [1:0]        rdy;
  logic [1:0]        ram_we;
  logic [1:0][2:0]   ram_addr;
  logic [1:0][31:0]  ram_wd;
  logic [1:0][3:0]   ram_be;
  logic [1:0][31:0]  ram_rd;
  logic [1:0]        rv;
  logic [1:0][31:0]  rdat;

  int total = 0;
  int bad   = 0;

  logic [31:0] ref_mem [8];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  int          outst [2];

  always #5 clk = ~clk;

  ram_sp_req_ctrl #(.WORD_BIT_WIDTH(32), .DEPTH(8), .READ_LATENCY(1)) u_dut_l1 (
    .i_clk(clk), .i_sync_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(rdy[0]), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_data(req_data), .i_req_byte_en(req_be),
    .o_ram_we(ram_we[0]), .o_ram_word_addr(ram_addr[0]), .o_ram_data(ram_wd[0]),
    .o_ram_wr_byte_en(ram_be[0]), .i_ram_data(ram_rd[0]),
    .o_rsp_valid(rv[0]), .i_rsp_ready(rsp_ready), .o_rsp_data(rdat[0])
  );

  ram_sp_req_ctrl #(.WORD_BIT_WIDTH(32), .DEPTH(8), .READ_LATENCY(2)) u_dut_l2 (
    .i_clk(clk), .i_sync_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(rdy[1]), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_data(req_data), .i_req_byte_en(req_be),
    .o_ram_we(ram_we[1]), .o_ram_word_addr(ram_addr[1]), .o_ram_data(ram_wd[1]),
    .o_ram_wr_byte_en(ram_be[1]), .i_ram_data(ram_rd[1]),
    .o_rsp_valid(rv[1]), .i_rsp_ready(rsp_ready), .o_rsp_data(rdat[1])
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Behavioral write-first RAMs, latency 1 and latency 2.
  logic [31:0] m0 [8];
  logic [31:0] m1 [8];
  logic [31:0] r0, r1a, r1b;

  always @(posedge clk) begin
    if (ram_we[0]) begin
      m0[ram_addr[0]] <= merge(m0[ram_addr[0]], ram_wd[0], ram_be[0]);
      r0              <= merge(m0[ram_addr[0]], ram_wd[0], ram_be[0]);
    end else begin
      r0 <= m0[ram_addr[0]];
    end
  end

  always @(posedge clk) begin
    if (ram_we[1]) begin
      m1[ram_addr[1]] <= merge(m1[ram_addr[1]], ram_wd[1], ram_be[1]);
      r1a             <= merge(m1[ram_addr[1]], ram_wd[1], ram_be[1]);
    end else begin
      r1a <= m1[ram_addr[1]];
    end
    r1b <= r1a;
  end

  assign ram_rd[0] = r0;
  assign ram_rd[1] = r1b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge, settle, and track writes.
  task automatic drive(input logic r, input logic v, input logic w, input logic [2:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic rr);
    @(negedge clk);
    rst = r; req_valid = v; req_we = w; req_addr = a; req_data = d; req_be = b;
    rsp_ready = rr;
    #1;
    if (!r && v && w) ref_mem[a] = merge(ref_mem[a], d, b);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b1);
  endtask

  task automatic exp_rsp(input string tag, input logic v0, input logic [31:0] d0,
                         input logic v1, input logic [31:0] d1);
    chk({tag, "_valid_L1"}, 32'(rv[0]), 32'(v0));
    if (v0) chk({tag, "_data_L1"}, rdat[0], d0);
    chk({tag, "_valid_L2"}, 32'(rv[1]), 32'(v1));
    if (v1) chk({tag, "_data_L2"}, rdat[1], d1);
  endtask

  // One random cycle checked against the reference memory and scoreboards.
  task automatic rnd_cycle(input logic v, input logic w, input logic [2:0] a,
                           input logic [31:0] d, input logic [3:0] b, input logic rr);
    logic        er;
    logic [31:0] ed;
    drive(1'b0, v, w, a, d, b, rr);
    for (int n = 0; n < 2; n++) begin
      er = w || (outst[n] < ((n == 0) ? 3 : 4));
      chk((n == 0) ? "rnd_ready_L1" : "rnd_ready_L2", 32'(rdy[n]), 32'(er));
      if (rv[n] && rr) begin
        if ((n == 0 ? q0.size() : q1.size()) == 0) begin
          chk((n == 0) ? "rnd_spurious_L1" : "rnd_spurious_L2", 32'(rv[n]), 32'd0);
        end else begin
          ed = (n == 0) ? q0.pop_front() : q1.pop_front();
          chk((n == 0) ? "rnd_data_L1" : "rnd_data_L2", rdat[n], ed);
          outst[n]--;
        end
      end
      if (v && !w && er) begin
        if (n == 0) q0.push_back(ref_mem[a]);
        else        q1.push_back(ref_mem[a]);
        outst[n]++;
      end
    end
  endtask

  initial begin
    // Power-on reset, then reads left in flight when reset hits again.
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 3'd1, 32'h0, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 3'd2, 32'h12345678, 4'hF, 1'b1);
      chk("rst_ready_L1", 32'(rdy[0]), 32'd0);
      chk("rst_ready_L2", 32'(rdy[1]), 32'd0);
      chk("rst_ram_we_L1", 32'(ram_we[0]), 32'd0);
      chk("rst_ram_we_L2", 32'(ram_we[1]), 32'd0);
      if (i > 0) exp_rsp("rst_rsp", 1'b0, 32'h0, 1'b0, 32'h0);
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      exp_rsp("post_rst_rsp", 1'b0, 32'h0, 1'b0, 32'h0);
    end
    chk("post_rst_ready_L1", 32'(rdy[0]), 32'd1);

    // Write then read next cycle; responses in c+2 (L1) and c+3 (L2).
    drive(1'b0, 1'b1, 1'b1, 3'd3, 32'hDEADBEEF, 4'hF, 1'b1);
    chk("wr_ram_we", 32'(ram_we[0]), 32'd1);
    chk("wr_ram_addr", 32'(ram_addr[1]), 32'd3);
    chk("wr_ram_data", ram_wd[0], 32'hDEADBEEF);
    chk("wr_ram_be", 32'(ram_be[1]), 32'hF);
    drive(1'b0, 1'b1, 1'b0, 3'd3, 32'h0, 4'hF, 1'b1);
    chk("rd_ready_L1", 32'(rdy[0]), 32'd1);
    chk("rd_ram_we", 32'(ram_we[0]), 32'd0);
    chk("rd_ram_be_forced", 32'(ram_be[0]), 32'd0);
    idle(); exp_rsp("rar_c1", 1'b0, 32'h0, 1'b0, 32'h0);
    idle(); exp_rsp("rar_c2", 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    idle(); exp_rsp("rar_c3", 1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
    idle(); exp_rsp("rar_c4", 1'b0, 32'h0, 1'b0, 32'h0);

    // Partial write merges bytes 0 and 2 only.
    drive(1'b0, 1'b1, 1'b1, 3'd5, 32'h11223344, 4'hF, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 3'd5, 32'hAABBCCDD, 4'h5, 1'b1);
    chk("pw_ram_be", 32'(ram_be[0]), 32'h5);
    drive(1'b0, 1'b1, 1'b0, 3'd5, 32'h0, 4'h0, 1'b1);
    idle();
    idle(); exp_rsp("pw_c2", 1'b1, 32'h11BB33DD, 1'b0, 32'h0);
    idle(); exp_rsp("pw_c3", 1'b0, 32'h0, 1'b1, 32'h11BB33DD);

    // Streaming: 16 back-to-back reads, no stalls, no gaps.
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b1, 3'(i), 32'hC0DE0000 + 32'(i), 4'hF, 1'b1);
    for (int j = 0; j < 20; j++) begin
      if (j < 16) begin
        drive(1'b0, 1'b1, 1'b0, 3'(j % 8), 32'h0, 4'h0, 1'b1);
        chk("stream_ready_L1", 32'(rdy[0]), 32'd1);
        chk("stream_ready_L2", 32'(rdy[1]), 32'd1);
      end else begin
        idle();
      end
      exp_rsp("stream", (j >= 2 && j < 18), 32'hC0DE0000 + 32'((j - 2) % 8),
              (j >= 3 && j < 19), 32'hC0DE0000 + 32'((j - 3) % 8));
    end

    // Back-pressure: L+2 reads accepted, writes still flow.
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b1, 1'b0, 3'(k), 32'h0, 4'h0, 1'b0);
      chk("bp_ready_L1", 32'(rdy[0]), 32'(k < 3));
      chk("bp_ready_L2", 32'(rdy[1]), 32'(k < 4));
    end
    drive(1'b0, 1'b1, 1'b1, 3'd7, 32'h77777777, 4'hF, 1'b0);
    chk("bp_wr_ready_L1", 32'(rdy[0]), 32'd1);
    chk("bp_wr_ready_L2", 32'(rdy[1]), 32'd1);
    chk("bp_wr_ram_we_L1", 32'(ram_we[0]), 32'd1);
    exp_rsp("bp_hold", 1'b1, 32'hC0DE0000, 1'b1, 32'hC0DE0000);
    drive(1'b0, 1'b1, 1'b0, 3'd4, 32'h0, 4'h0, 1'b1);
    chk("bp_full_fire_ready_L1", 32'(rdy[0]), 32'd0);
    chk("bp_full_fire_ready_L2", 32'(rdy[1]), 32'd0);
    exp_rsp("bp_d0", 1'b1, 32'hC0DE0000, 1'b1, 32'hC0DE0000);
    idle();
    chk("bp_credit_ready_L1", 32'(rdy[0]), 32'd1);
    chk("bp_credit_ready_L2", 32'(rdy[1]), 32'd1);
    exp_rsp("bp_d1", 1'b1, 32'hC0DE0001, 1'b1, 32'hC0DE0001);
    idle(); exp_rsp("bp_d2", 1'b1, 32'hC0DE0002, 1'b1, 32'hC0DE0002);
    idle(); exp_rsp("bp_d3", 1'b0, 32'h0, 1'b1, 32'hC0DE0003);
    idle(); exp_rsp("bp_d4", 1'b0, 32'h0, 1'b0, 32'h0);

    // Random mix against the reference memory, then drain.
    outst[0] = 0;
    outst[1] = 0;
    for (int c = 0; c < 10000; c++) begin
      rnd_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
                $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 10; c++) rnd_cycle(1'b0, 1'b0, 3'd0, 32'h0, 4'h0, 1'b1);
    chk("drain_empty_L1", 32'(q0.size()), 32'd0);
    chk("drain_empty_L2", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
